// File: rtl/vram_write_arbiter_pkg.sv
// Shared definitions for the VRAM write arbiter: geometry, fill FSM states, address packing.
// Clamp helpers are used when VRAM_ARB_CLIP_EN is defined.
package vram_write_arbiter_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int CW     = 3;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;
  localparam int ADDR_W = COL_W + ROW_W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] row);
    return {col, row};
  endfunction

  function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W-1:0] col);
    return (col > COL_LAST) ? COL_LAST : col;
  endfunction

  function automatic logic [ROW_W-1:0] clamp_row(input logic [ROW_W-1:0] row);
    return (row > ROW_LAST) ? ROW_LAST : row;
  endfunction

endpackage

// File: rtl/vram_write_arbiter_scanner.sv
// Rectangle scanner: normalises corners, holds bounds and the row-major cursor.
// With VRAM_ARB_CLIP_EN corners are clamped instead of flagged out of range.
module vram_fill_scanner
  import vram_write_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_stall,
  input  logic [COL_W-1:0] i_col0,
  input  logic [COL_W-1:0] i_col1,
  input  logic [ROW_W-1:0] i_row0,
  input  logic [ROW_W-1:0] i_row1,
  output logic             o_range_err,
  output logic             o_last,
  output logic [COL_W-1:0] o_cur_col,
  output logic [ROW_W-1:0] o_cur_row
);

  logic [COL_W-1:0] w_c0, w_c1, w_cmin, w_cmax;
  logic [ROW_W-1:0] w_r0, w_r1, w_rmin, w_rmax;
  logic [COL_W-1:0] r_cmin, r_cmax, r_cur_col;
  logic [ROW_W-1:0] r_rmax, r_cur_row;

`ifdef VRAM_ARB_CLIP_EN
  assign w_c0        = clamp_col(i_col0);
  assign w_c1        = clamp_col(i_col1);
  assign w_r0        = clamp_row(i_row0);
  assign w_r1        = clamp_row(i_row1);
  assign o_range_err = 1'b0;
`else
  assign w_c0        = i_col0;
  assign w_c1        = i_col1;
  assign w_r0        = i_row0;
  assign w_r1        = i_row1;
  assign o_range_err = (i_col0 > COL_LAST) || (i_col1 > COL_LAST) ||
                       (i_row0 > ROW_LAST) || (i_row1 > ROW_LAST);
`endif

  assign w_cmin = (w_c0 < w_c1) ? w_c0 : w_c1;
  assign w_cmax = (w_c0 < w_c1) ? w_c1 : w_c0;
  assign w_rmin = (w_r0 < w_r1) ? w_r0 : w_r1;
  assign w_rmax = (w_r0 < w_r1) ? w_r1 : w_r0;

  // The cursor only moves on cycles where the fill pixel was actually written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmin    <= '0;
      r_cmax    <= '0;
      r_rmax    <= '0;
      r_cur_col <= '0;
      r_cur_row <= '0;
    end else if (i_load) begin
      r_cmin    <= w_cmin;
      r_cmax    <= w_cmax;
      r_rmax    <= w_rmax;
      r_cur_col <= w_cmin;
      r_cur_row <= w_rmin;
    end else if (i_run && !i_stall) begin
      if (r_cur_col == r_cmax) begin
        r_cur_col <= r_cmin;
        r_cur_row <= r_cur_row + 1'b1;
      end else begin
        r_cur_col <= r_cur_col + 1'b1;
      end
    end
  end

  assign o_last    = (r_cur_col == r_cmax) && (r_cur_row == r_rmax);
  assign o_cur_col = r_cur_col;
  assign o_cur_row = r_cur_row;

endmodule

// File: rtl/vram_write_arbiter.sv
// Single VRAM write port shared by CPU pixel writes (always win) and a rectangle-fill engine.
// Define VRAM_ARB_CLIP_EN to clamp out-of-range coordinates instead of dropping/rejecting.
module vram_write_arbiter
  import vram_write_arbiter_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iCpuReq,
  input  logic [COL_W-1:0]  iCpuCol,
  input  logic [ROW_W-1:0]  iCpuRow,
  input  logic [CW-1:0]     iCpuColor,
  input  logic              iFillStart,
  input  logic [COL_W-1:0]  iFillCol0,
  input  logic [COL_W-1:0]  iFillCol1,
  input  logic [ROW_W-1:0]  iFillRow0,
  input  logic [ROW_W-1:0]  iFillRow1,
  input  logic [CW-1:0]     iFillColor,
  input  logic              iFillAbort,
  output logic              oFillBusy,
  output logic              oFillDone,
  output logic              oFillErr,
  output logic              oWriteEnable,
  output logic [ADDR_W-1:0] oWriteAddress,
  output logic [CW-1:0]     oDataIn
);

  fill_state_t       r_state;
  logic [COL_W-1:0]  r_col0, r_col1;
  logic [ROW_W-1:0]  r_row0, r_row1;
  logic [CW-1:0]     r_fill_color;
  logic              r_we, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_data;

  logic              w_range_err, w_last, w_cpu_ok, w_fill_write, w_load, w_run;
  logic [COL_W-1:0]  w_cur_col, w_cpu_col;
  logic [ROW_W-1:0]  w_cur_row, w_cpu_row;

`ifdef VRAM_ARB_CLIP_EN
  assign w_cpu_col = clamp_col(iCpuCol);
  assign w_cpu_row = clamp_row(iCpuRow);
  assign w_cpu_ok  = iCpuReq;
`else
  assign w_cpu_col = iCpuCol;
  assign w_cpu_row = iCpuRow;
  assign w_cpu_ok  = iCpuReq && (iCpuCol <= COL_LAST) && (iCpuRow <= ROW_LAST);
`endif

  // Any CPU request occupies the slot, so the fill pixel is held and retried.
  assign w_load       = (r_state == LOAD);
  assign w_run        = (r_state == RUN) && !iFillAbort;
  assign w_fill_write = w_run && !iCpuReq;

  vram_fill_scanner u_scanner (
    .clk         (Clock),
    .rst_n       (Reset),
    .i_load      (w_load),
    .i_run       (w_run),
    .i_stall     (iCpuReq),
    .i_col0      (r_col0),
    .i_col1      (r_col1),
    .i_row0      (r_row0),
    .i_row1      (r_row1),
    .o_range_err (w_range_err),
    .o_last      (w_last),
    .o_cur_col   (w_cur_col),
    .o_cur_row   (w_cur_row)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_col0       <= '0;
      r_col1       <= '0;
      r_row0       <= '0;
      r_row1       <= '0;
      r_fill_color <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_cpu_ok) begin
        r_we   <= 1'b1;
        r_addr <= pack_addr(w_cpu_col, w_cpu_row);
        r_data <= iCpuColor;
      end else if (w_fill_write) begin
        r_we   <= 1'b1;
        r_addr <= pack_addr(w_cur_col, w_cur_row);
        r_data <= r_fill_color;
      end else begin
        r_we   <= 1'b0;
      end

      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iFillStart) begin
            r_col0       <= iFillCol0;
            r_col1       <= iFillCol1;
            r_row0       <= iFillRow0;
            r_row1       <= iFillRow1;
            r_fill_color <= iFillColor;
            r_busy       <= 1'b1;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          if (iFillAbort || w_range_err) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (iFillAbort) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= DONE;
          end else if (w_fill_write && w_last) begin
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign oFillBusy     = r_busy;
  assign oFillDone     = r_done;
  assign oFillErr      = r_err;
  assign oWriteEnable  = r_we;
  assign oWriteAddress = r_addr;
  assign oDataIn       = r_data;

endmodule
